// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the two-port SRAM arbiter.
package sram_arbiter_pkg;

    localparam int SRAM_AW  = 18;
    localparam int SRAM_DW  = 32;
    localparam int SRAM_BEW = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Client-side request bus shared by both SRAM requesters.
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic [1:0]            i_req;
    logic [1:0]            i_we;
    logic [2*SRAM_AW-1:0]  i_addr;
    logic [2*SRAM_DW-1:0]  i_wdata;
    logic [2*SRAM_BEW-1:0] i_be;
    logic [1:0]            o_ack;
    logic [SRAM_DW-1:0]    o_rdata;

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_be,
        input  o_ack, o_rdata
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_be,
        output o_ack, o_rdata
    );

endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant; last = port granted most recently.
module sram_rr_arbiter (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic [1:0] gnt
);

    logic [1:0] eff;

    always_comb begin
        eff = req & ~mask;
        gnt = eff;
        if (eff == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter driving fixed-timing async SRAM cycles.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_x,
    sram_arbiter_if.slave       bus,
    output logic [SRAM_AW-1:0]  o_sram_a,
    output logic                o_sram_we_x,
    output logic                o_sram_oe_x,
    output logic [1:0]          o_sram_ce_x,
    output logic [SRAM_BEW-1:0] o_sram_bl_x,
    output logic [SRAM_DW-1:0]  o_sram_wd,
    output logic                o_sram_drv,
    input  logic [SRAM_DW-1:0]  i_sram_rd
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic                ptr, ptr_n;
    logic                port, port_n;
    logic                sel;
    logic [1:0]          gnt;
    logic [1:0]          ack_n;
    logic [SRAM_DW-1:0]  rdata_n;
    logic [SRAM_AW-1:0]  a_n;
    logic                we_n, oe_n, drv_n;
    logic [1:0]          ce_n;
    logic [SRAM_BEW-1:0] bl_n;
    logic [SRAM_DW-1:0]  wd_n;

    // A port acked this cycle is masked so it may drop req on the ack edge
    sram_rr_arbiter u_rr (
        .req  (bus.i_req),
        .mask (bus.o_ack),
        .last (ptr),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ptr         <= 1'b1;
            port        <= 1'b0;
            bus.o_ack   <= 2'b00;
            bus.o_rdata <= '0;
            o_sram_a    <= '0;
            o_sram_we_x <= 1'b1;
            o_sram_oe_x <= 1'b1;
            o_sram_ce_x <= 2'b11;
            o_sram_bl_x <= 4'hf;
            o_sram_wd   <= '0;
            o_sram_drv  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ptr         <= ptr_n;
            port        <= port_n;
            bus.o_ack   <= ack_n;
            bus.o_rdata <= rdata_n;
            o_sram_a    <= a_n;
            o_sram_we_x <= we_n;
            o_sram_oe_x <= oe_n;
            o_sram_ce_x <= ce_n;
            o_sram_bl_x <= bl_n;
            o_sram_wd   <= wd_n;
            o_sram_drv  <= drv_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        port_n  = port;
        ack_n   = 2'b00;
        rdata_n = bus.o_rdata;
        a_n     = o_sram_a;
        we_n    = o_sram_we_x;
        oe_n    = o_sram_oe_x;
        ce_n    = o_sram_ce_x;
        bl_n    = o_sram_bl_x;
        wd_n    = o_sram_wd;
        drv_n   = o_sram_drv;
        sel     = gnt[1];
        unique case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    ptr_n  = sel;
                    port_n = sel;
                    a_n    = sel ? bus.i_addr[2*SRAM_AW-1:SRAM_AW]
                                 : bus.i_addr[SRAM_AW-1:0];
                    ce_n   = 2'b00;
                    if (bus.i_we[sel]) begin
                        wd_n    = sel ? bus.i_wdata[2*SRAM_DW-1:SRAM_DW]
                                      : bus.i_wdata[SRAM_DW-1:0];
                        bl_n    = sel ? ~bus.i_be[2*SRAM_BEW-1:SRAM_BEW]
                                      : ~bus.i_be[SRAM_BEW-1:0];
                        drv_n   = 1'b1;
                        we_n    = 1'b1;
                        state_n = WR_SETUP;
                    end else begin
                        bl_n    = 4'h0;
                        oe_n    = 1'b0;
                        cnt_n   = CNT_LOAD;
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (cnt == 4'd0) begin
                    rdata_n = i_sram_rd;
                    ack_n   = port ? 2'b10 : 2'b01;
                    oe_n    = 1'b1;
                    ce_n    = 2'b11;
                    bl_n    = 4'hf;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            WR_SETUP: begin
                we_n    = 1'b0;
                cnt_n   = CNT_LOAD;
                state_n = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt == 4'd0) begin
                    we_n    = 1'b1;
                    state_n = WR_HOLD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            WR_HOLD: begin
                ack_n   = port ? 2'b10 : 2'b01;
                drv_n   = 1'b0;
                ce_n    = 2'b11;
                bl_n    = 4'hf;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter at WAIT_CYCLES 1 and 3.
module tb_sram_arbiter;

    typedef struct {
        bit          port;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_x = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if b1 ();
    sram_arbiter_if b3 ();

    logic [17:0] a1, a3;
    logic        we1, we3, oe1, oe3, drv1, drv3;
    logic [1:0]  ce1, ce3;
    logic [3:0]  bl1, bl3;
    logic [31:0] wd1, wd3;
    logic [31:0] sram_rd = 32'h0;

    sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_x(rst_x), .bus(b1.slave),
        .o_sram_a(a1), .o_sram_we_x(we1), .o_sram_oe_x(oe1),
        .o_sram_ce_x(ce1), .o_sram_bl_x(bl1), .o_sram_wd(wd1),
        .o_sram_drv(drv1), .i_sram_rd(sram_rd)
    );

    sram_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_x(rst_x), .bus(b3.slave),
        .o_sram_a(a3), .o_sram_we_x(we3), .o_sram_oe_x(oe3),
        .o_sram_ce_x(ce3), .o_sram_bl_x(bl3), .o_sram_wd(wd3),
        .o_sram_drv(drv3), .i_sram_rd(sram_rd)
    );

    // Stimulus goes to whichever DUT is selected; the other sees no requests
    logic        sel3 = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [35:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;

    assign b1.i_req   = sel3 ? 2'b00 : req;
    assign b3.i_req   = sel3 ? req : 2'b00;
    assign b1.i_we    = we;
    assign b3.i_we    = we;
    assign b1.i_addr  = addr;
    assign b3.i_addr  = addr;
    assign b1.i_wdata = wdata;
    assign b3.i_wdata = wdata;
    assign b1.i_be    = be;
    assign b3.i_be    = be;

    wire [1:0]  ack   = sel3 ? b3.o_ack : b1.o_ack;
    wire [31:0] rdata = sel3 ? b3.o_rdata : b1.o_rdata;
    wire [17:0] sa    = sel3 ? a3 : a1;
    wire        swe   = sel3 ? we3 : we1;
    wire        soe   = sel3 ? oe3 : oe1;
    wire [1:0]  sce   = sel3 ? ce3 : ce1;
    wire [3:0]  sbl   = sel3 ? bl3 : bl1;
    wire [31:0] swd   = sel3 ? wd3 : wd1;
    wire        sdrv  = sel3 ? drv3 : drv1;

    // SRAM model: byte lanes written on clk edges while WE and CE are low
    bit [31:0] mem [int];

    always @(posedge clk) begin
        bit [31:0] t;
        if (sce == 2'b00 && !swe) begin
            t = mem.exists(int'(sa)) ? mem[int'(sa)] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (!sbl[i]) t[8*i +: 8] = swd[8*i +: 8];
            mem[int'(sa)] = t;
        end
    end

    always @(negedge clk) begin
        if (!soe && sce == 2'b00)
            sram_rd = mem.exists(int'(sa)) ? mem[int'(sa)] : 32'h0;
        else
            sram_rd = 32'h0;
    end

    // Bus-rule monitor: accumulates events for the main sequence to judge
    int          wlow_tot = 0;
    int          oelow_tot = 0;
    int          ovl = 0;
    int          a_chg = 0;
    int          dbl = 0;
    int          ack_tot = 0;
    logic [3:0]  last_bl = 4'hf;
    logic        prev_we = 1'b1;
    logic [17:0] prev_a = '0;

    always @(negedge clk) begin
        if (!swe) begin
            wlow_tot++;
            last_bl = sbl;
            if (!prev_we && sa != prev_a) a_chg++;
        end
        if (!soe) oelow_tot++;
        if (!soe && sdrv) ovl++;
        if (ack == 2'b11) dbl++;
        if (ack != 2'b00) ack_tot++;
        prev_we = swe;
        prev_a  = sa;
    end

    int        checks = 0;
    int        errors = 0;
    int        pushes = 0;
    exp_t      sb [$];
    bit [31:0] ref_mem [int];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input bit p, input bit wr, input logic [17:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        exp_t      e;
        bit [31:0] t;
        t = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) t[8*i +: 8] = d[8*i +: 8];
            ref_mem[int'(a)] = t;
        end
        e.port = p;
        e.rd   = !wr;
        e.data = t;
        sb.push_back(e);
        pushes++;
    endtask

    task automatic sb_check();
        exp_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_port", 64'(ack), e.port ? 64'd2 : 64'd1);
            if (e.rd) chk("rdata", 64'(rdata), 64'(e.data));
        end
    endtask

    // Caller is aligned just after a posedge; returns likewise
    task automatic xfer(input bit p, input bit wr, input logic [17:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input int wc, input logic [3:0] bl_exp);
        int n, w0, o0;
        we[p]            = wr;
        addr[p*18 +: 18] = a;
        wdata[p*32 +: 32] = d;
        be[p*4 +: 4]     = b;
        push(p, wr, a, d, b);
        w0 = wlow_tot;
        o0 = oelow_tot;
        req[p] = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[p] && n < 40);
        chk(wr ? "wr_latency" : "rd_latency", 64'(n),
            wr ? 64'(wc + 3) : 64'(wc + 1));
        sb_check();
        if (wr) begin
            chk("we_low_cycles", 64'(wlow_tot - w0), 64'(wc));
            chk("bl_during_pulse", 64'(last_bl), 64'(bl_exp));
        end else begin
            chk("oe_low_cycles", 64'(oelow_tot - o0), 64'(wc));
        end
        @(posedge clk);
        #1 req[p] = 1'b0;
    endtask

    initial begin
        int done0, done1, n;

        repeat (3) @(posedge clk);
        #1 rst_x = 1'b1;

        xfer(1'b0, 1'b1, 18'h00012, 32'hDEADBEEF, 4'hf, 1, 4'h0);
        xfer(1'b1, 1'b0, 18'h00012, 32'h0, 4'h0, 1, 4'h0);
        xfer(1'b0, 1'b1, 18'h00012, 32'h00AA0000, 4'b0100, 1, 4'b1011);
        xfer(1'b1, 1'b0, 18'h00012, 32'h0, 4'h0, 1, 4'h0);
        xfer(1'b1, 1'b1, 18'h00012, 32'hFFFFFFFF, 4'h0, 1, 4'hf);
        xfer(1'b0, 1'b0, 18'h00012, 32'h0, 4'h0, 1, 4'h0);

        // Reset held three cycles in the middle of a write
        we[0] = 1'b1;
        addr[17:0] = 18'h00040;
        wdata[31:0] = 32'h00000055;
        be[3:0] = 4'hf;
        req[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_x = 1'b0;
        req = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_addr", 64'(sa), 64'd0);
        chk("rst_we_x", 64'(swe), 64'd1);
        chk("rst_oe_x", 64'(soe), 64'd1);
        chk("rst_ce_x", 64'(sce), 64'd3);
        chk("rst_bl_x", 64'(sbl), 64'hf);
        chk("rst_wd", 64'(swd), 64'd0);
        chk("rst_drv", 64'(sdrv), 64'd0);
        @(posedge clk);
        #1 rst_x = 1'b1;

        // Contention: port0 reads, port1 writes, both held; grants alternate
        we = 2'b10;
        addr = {18'h00034, 18'h00012};
        wdata = {32'h12345678, 32'h0};
        be = 8'hf0;
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 1'b0, 18'h00012, 32'h0, 4'h0);
            push(1'b1, 1'b1, 18'h00034, 32'h12345678, 4'hf);
        end
        req = 2'b11;
        done0 = 0;
        done1 = 0;
        n = 0;
        while (done0 + done1 < 8 && n < 200) begin
            @(negedge clk);
            n++;
            if (ack != 2'b00) begin
                sb_check();
                if (ack[0]) done0++;
                if (ack[1]) done1++;
                if (done0 == 4) req[0] = 1'b0;
                if (done1 == 4) req[1] = 1'b0;
            end
        end
        chk("contention_done", 64'(done0 + done1), 64'd8);
        req = 2'b00;
        @(posedge clk);
        #1;
        xfer(1'b0, 1'b0, 18'h00034, 32'h0, 4'h0, 1, 4'h0);

        // Longer wait states on the second instance
        sel3 = 1'b1;
        @(posedge clk);
        #1;
        xfer(1'b0, 1'b0, 18'h00012, 32'h0, 4'h0, 3, 4'h0);
        xfer(1'b1, 1'b1, 18'h00050, 32'hCAFEF00D, 4'hf, 3, 4'h0);
        xfer(1'b0, 1'b0, 18'h00050, 32'h0, 4'h0, 3, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("no_oe_drv_overlap", 64'(ovl), 64'd0);
        chk("addr_stable_we_low", 64'(a_chg), 64'd0);
        chk("no_double_ack", 64'(dbl), 64'd0);
        chk("ack_total", 64'(ack_tot), 64'(pushes));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
